// File: rtl/arm_pkg.sv
// Shared encodings for the ARM decode stage: ALU commands, opcodes, condition codes,
// instruction modes and the ID/EX register layout.
package arm_pkg;

    localparam logic [3:0] CMD_NONE = 4'b0000;
    localparam logic [3:0] CMD_MOV  = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_ADC  = 4'b0011;
    localparam logic [3:0] CMD_SUB  = 4'b0100;
    localparam logic [3:0] CMD_SBC  = 4'b0101;
    localparam logic [3:0] CMD_AND  = 4'b0110;
    localparam logic [3:0] CMD_ORR  = 4'b0111;
    localparam logic [3:0] CMD_EOR  = 4'b1000;
    localparam logic [3:0] CMD_MVN  = 4'b1001;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  dest;
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        b;
        logic        s;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } idex_t;

    // sr is {N,Z,C,V}; cond 1111 is never-execute.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v;
        {n, z, c, v} = sr;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_register_file.sv
// R0-R14 general registers with two write-through read ports; address 15 reads the PC.
module arm_register_file
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  rd_addr1,
    input  logic [3:0]  rd_addr2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    input  logic [31:0] pc_in,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs_q [15];
    logic [31:0] regs_d [15];

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < 15; i++) begin
            if (wr_en && wr_addr == 4'(i)) regs_d[i] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reading regs_d gives the same-cycle bypass of an incoming write for free.
    function automatic logic [31:0] read_port(input logic [3:0] addr);
        logic [31:0] val;
        val = pc_in;
        for (int i = 0; i < 15; i++) begin
            if (addr == 4'(i)) val = regs_d[i];
        end
        return val;
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
        rd_data2 = read_port(rd_addr2);
    end

endmodule

// File: rtl/stage_id.sv
// Instruction-decode stage: field decode, condition check, control generation,
// register-file reads and the ID/EX pipeline register.
module stage_id
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_in,
    input  logic [31:0] Instruction,
    input  logic        flush,
    input  logic        hazard,
    input  logic [3:0]  SR,
    input  logic        WB_en,
    input  logic [3:0]  WB_dest,
    input  logic [31:0] WB_value,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        two_src,
    output logic [31:0] PC,
    output logic [31:0] Val_Rn,
    output logic [31:0] Val_Rm,
    output logic [3:0]  Dest,
    output logic [3:0]  EXE_CMD,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic        WB_EN,
    output logic        B,
    output logic        S,
    output logic        imm,
    output logic [11:0] Shift_operand,
    output logic [23:0] Signed_imm_24,
    output logic [3:0]  src1_out,
    output logic [3:0]  src2_out
);

    logic [3:0]  cond, opcode, rn, rd, rm;
    mode_e       mode;
    logic        i_bit, s_bit, store;
    logic [31:0] rn_val, rm_val;
    logic [3:0]  exe_cmd;
    logic        mem_r, mem_w, wb, br, s_out, bubble;
    idex_t       idex_d, idex_q;

    always_comb begin
        cond    = Instruction[31:28];
        mode    = mode_e'(Instruction[27:26]);
        i_bit   = Instruction[25];
        opcode  = Instruction[24:21];
        s_bit   = Instruction[20];
        rn      = Instruction[19:16];
        rd      = Instruction[15:12];
        rm      = Instruction[3:0];
        store   = (mode == MODE_MEM) && !s_bit;
        src1    = rn;
        src2    = store ? rd : rm;
        two_src = ~i_bit | store;
    end

    arm_register_file u_rf (
        .clk      (clk),
        .rst_n    (rst),
        .rd_addr1 (src1),
        .rd_addr2 (src2),
        .rd_data1 (rn_val),
        .rd_data2 (rm_val),
        .pc_in    (PC_in),
        .wr_en    (WB_en),
        .wr_addr  (WB_dest),
        .wr_data  (WB_value)
    );

    always_comb begin
        exe_cmd = CMD_NONE;
        mem_r   = 1'b0;
        mem_w   = 1'b0;
        wb      = 1'b0;
        br      = 1'b0;
        s_out   = 1'b0;
        case (mode)
            MODE_DP: begin
                s_out = s_bit;
                wb    = 1'b1;
                case (opcode)
                    OP_MOV:  exe_cmd = CMD_MOV;
                    OP_MVN:  exe_cmd = CMD_MVN;
                    OP_ADD:  exe_cmd = CMD_ADD;
                    OP_ADC:  exe_cmd = CMD_ADC;
                    OP_SUB:  exe_cmd = CMD_SUB;
                    OP_SBC:  exe_cmd = CMD_SBC;
                    OP_AND:  exe_cmd = CMD_AND;
                    OP_ORR:  exe_cmd = CMD_ORR;
                    OP_EOR:  exe_cmd = CMD_EOR;
                    OP_CMP: begin exe_cmd = CMD_SUB; wb = 1'b0; end
                    OP_TST: begin exe_cmd = CMD_AND; wb = 1'b0; end
                    default: begin wb = 1'b0; s_out = 1'b0; end
                endcase
            end
            MODE_MEM: begin
                exe_cmd = CMD_ADD;
                mem_r   = s_bit;
                wb      = s_bit;
                mem_w   = ~s_bit;
            end
            MODE_BR:  br = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        bubble               = flush | hazard | ~cond_pass(cond, SR);
        idex_d.pc            = PC_in;
        idex_d.val_rn        = rn_val;
        idex_d.val_rm        = rm_val;
        idex_d.dest          = rd;
        idex_d.exe_cmd       = bubble ? 4'b0000 : exe_cmd;
        idex_d.mem_r_en      = mem_r & ~bubble;
        idex_d.mem_w_en      = mem_w & ~bubble;
        idex_d.wb_en         = wb & ~bubble;
        idex_d.b             = br & ~bubble;
        idex_d.s             = s_out & ~bubble;
        idex_d.imm           = i_bit;
        idex_d.shift_operand = Instruction[11:0];
        idex_d.signed_imm_24 = Instruction[23:0];
        idex_d.src1          = src1;
        idex_d.src2          = src2;
        // A flushed slot must not look like a forwarding source downstream.
        if (flush) begin
            idex_d.dest = 4'd0;
            idex_d.src1 = 4'd0;
            idex_d.src2 = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    assign PC            = idex_q.pc;
    assign Val_Rn        = idex_q.val_rn;
    assign Val_Rm        = idex_q.val_rm;
    assign Dest          = idex_q.dest;
    assign EXE_CMD       = idex_q.exe_cmd;
    assign MEM_R_EN      = idex_q.mem_r_en;
    assign MEM_W_EN      = idex_q.mem_w_en;
    assign WB_EN         = idex_q.wb_en;
    assign B             = idex_q.b;
    assign S             = idex_q.s;
    assign imm           = idex_q.imm;
    assign Shift_operand = idex_q.shift_operand;
    assign Signed_imm_24 = idex_q.signed_imm_24;
    assign src1_out      = idex_q.src1;
    assign src2_out      = idex_q.src2;

endmodule

// File: tb/tb_stage_id.sv
// Directed bench for stage_id with hand-computed expectations.
module tb_stage_id;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC_in = '0, Instruction = '0;
    logic        flush = 1'b0, hazard = 1'b0;
    logic [3:0]  SR = '0;
    logic        WB_en = 1'b0;
    logic [3:0]  WB_dest = '0;
    logic [31:0] WB_value = '0;
    logic [3:0]  src1, src2, Dest, EXE_CMD, src1_out, src2_out;
    logic        two_src, MEM_R_EN, MEM_W_EN, WB_EN, B, S, imm;
    logic [31:0] PC, Val_Rn, Val_Rm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_ADD   = 32'hE082_1003;
    localparam logic [31:0] I_MOVEQ = 32'h03A0_0001;
    localparam logic [31:0] I_STR   = 32'hE585_4000;
    localparam logic [31:0] I_LDR   = 32'hE595_4000;
    localparam logic [31:0] I_B     = 32'hEA00_0010;
    localparam logic [31:0] I_CMP   = 32'hE152_0003;
    localparam logic [31:0] I_ADDGT = 32'hC082_1003;
    localparam logic [31:0] I_ADDNV = 32'hF082_1003;
    localparam logic [31:0] I_ADDPC = 32'hE08F_1003;

    stage_id dut (
        .clk(clk), .rst(rst), .PC_in(PC_in), .Instruction(Instruction),
        .flush(flush), .hazard(hazard), .SR(SR),
        .WB_en(WB_en), .WB_dest(WB_dest), .WB_value(WB_value),
        .src1(src1), .src2(src2), .two_src(two_src),
        .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .Dest(Dest), .EXE_CMD(EXE_CMD),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .B(B), .S(S), .imm(imm),
        .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
        .src1_out(src1_out), .src2_out(src2_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [3:0] dest, input logic [31:0] val);
        WB_en = 1'b1; WB_dest = dest; WB_value = val;
        step();
        WB_en = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_pc", PC, 32'h0);
        check("rst_wb_en", 32'(WB_EN), 32'h0);
        check("rst_dest", 32'(Dest), 32'h0);
        check("rst_exe_cmd", 32'(EXE_CMD), 32'h0);
        step(); step();
        rst = 1'b1;

        wb_write(4'd2, 32'd5);
        wb_write(4'd3, 32'd7);
        wb_write(4'd4, 32'h44);

        // ADD R1,R2,R3
        Instruction = I_ADD; PC_in = 32'h100; SR = 4'b0000;
        #1;
        check("add_src1", 32'(src1), 32'd2);
        check("add_src2", 32'(src2), 32'd3);
        check("add_two_src", 32'(two_src), 32'd1);
        step();
        check("add_exe_cmd", 32'(EXE_CMD), 32'h2);
        check("add_wb_en", 32'(WB_EN), 32'h1);
        check("add_dest", 32'(Dest), 32'h1);
        check("add_val_rn", Val_Rn, 32'd5);
        check("add_val_rm", Val_Rm, 32'd7);
        check("add_imm", 32'(imm), 32'h0);
        check("add_pc", PC, 32'h100);
        check("add_src2_out", 32'(src2_out), 32'd3);
        check("add_shift_op", 32'(Shift_operand), 32'h003);

        // MOVEQ R0,#1: fails with Z=0, executes with Z=1
        Instruction = I_MOVEQ; SR = 4'b0000;
        #1;
        check("moveq_two_src", 32'(two_src), 32'd0);
        step();
        check("moveq_z0_exe_cmd", 32'(EXE_CMD), 32'h0);
        check("moveq_z0_wb_en", 32'(WB_EN), 32'h0);
        check("moveq_z0_imm", 32'(imm), 32'h1);
        SR = 4'b0100;
        step();
        check("moveq_z1_exe_cmd", 32'(EXE_CMD), 32'h1);
        check("moveq_z1_wb_en", 32'(WB_EN), 32'h1);
        check("moveq_z1_imm", 32'(imm), 32'h1);
        SR = 4'b0000;

        // STR R4,[R5]
        Instruction = I_STR;
        #1;
        check("str_src1", 32'(src1), 32'd5);
        check("str_src2", 32'(src2), 32'd4);
        check("str_two_src", 32'(two_src), 32'd1);
        step();
        check("str_mem_w_en", 32'(MEM_W_EN), 32'h1);
        check("str_mem_r_en", 32'(MEM_R_EN), 32'h0);
        check("str_wb_en", 32'(WB_EN), 32'h0);
        check("str_exe_cmd", 32'(EXE_CMD), 32'h2);
        check("str_val_rm", Val_Rm, 32'h44);

        // LDR R4,[R5]
        Instruction = I_LDR;
        #1;
        check("ldr_src2", 32'(src2), 32'd0);
        step();
        check("ldr_mem_r_en", 32'(MEM_R_EN), 32'h1);
        check("ldr_mem_w_en", 32'(MEM_W_EN), 32'h0);
        check("ldr_wb_en", 32'(WB_EN), 32'h1);
        check("ldr_s", 32'(S), 32'h0);

        // CMP R2,R3
        Instruction = I_CMP;
        step();
        check("cmp_exe_cmd", 32'(EXE_CMD), 32'h4);
        check("cmp_wb_en", 32'(WB_EN), 32'h0);
        check("cmp_s", 32'(S), 32'h1);

        // Write-through on R2 while decoding ADD
        Instruction = I_ADD;
        WB_en = 1'b1; WB_dest = 4'd2; WB_value = 32'hDEAD_BEEF;
        step();
        WB_en = 1'b0;
        check("wt_val_rn", Val_Rn, 32'hDEAD_BEEF);
        step();
        check("wt_stored_val_rn", Val_Rn, 32'hDEAD_BEEF);

        // Branch, then flush+hazard, then hazard alone
        Instruction = I_B;
        step();
        check("b_b", 32'(B), 32'h1);
        check("b_wb_en", 32'(WB_EN), 32'h0);
        check("b_simm24", 32'(Signed_imm_24), 32'h000010);
        flush = 1'b1; hazard = 1'b1;
        step();
        check("flush_b", 32'(B), 32'h0);
        check("flush_dest", 32'(Dest), 32'h0);
        check("flush_wb_en", 32'(WB_EN), 32'h0);
        Instruction = I_ADD;
        step();
        check("flush_add_dest", 32'(Dest), 32'h0);
        check("flush_add_src1_out", 32'(src1_out), 32'h0);
        check("flush_add_exe_cmd", 32'(EXE_CMD), 32'h0);
        flush = 1'b0;
        step();
        check("hazard_wb_en", 32'(WB_EN), 32'h0);
        check("hazard_dest", 32'(Dest), 32'h1);
        check("hazard_src1_out", 32'(src1_out), 32'h2);
        hazard = 1'b0;

        // GT with N=1,V=0 fails; N=1,V=1,Z=0 passes; cond 1111 never
        Instruction = I_ADDGT; SR = 4'b1000;
        step();
        check("gt_fail_wb_en", 32'(WB_EN), 32'h0);
        SR = 4'b1001;
        step();
        check("gt_pass_wb_en", 32'(WB_EN), 32'h1);
        Instruction = I_ADDNV; SR = 4'b0000;
        step();
        check("nv_wb_en", 32'(WB_EN), 32'h0);

        // R15 read returns PC_in
        Instruction = I_ADDPC; PC_in = 32'h0000_0ABC;
        step();
        check("r15_val_rn", Val_Rn, 32'h0000_0ABC);

        // Reset mid-stream
        Instruction = I_ADD; PC_in = 32'h200;
        step();
        check("pre_rst_wb_en", 32'(WB_EN), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_wb_en", 32'(WB_EN), 32'h0);
        check("mid_rst_pc", PC, 32'h0);
        check("mid_rst_dest", 32'(Dest), 32'h0);
        check("mid_rst_exe_cmd", 32'(EXE_CMD), 32'h0);
        step();
        check("held_rst_wb_en", 32'(WB_EN), 32'h0);
        rst = 1'b1;
        step();
        check("post_rst_wb_en", 32'(WB_EN), 32'h1);
        check("post_rst_pc", PC, 32'h200);
        check("post_rst_r3", Val_Rm, 32'h0);
        check("post_rst_r2", Val_Rn, 32'h0);
        wb_write(4'd15, 32'h1234_5678);
        step();
        check("wb15_r2", Val_Rn, 32'h0);
        check("wb15_r3", Val_Rm, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
